mon_pro_seq: RTL and testbench

- Word-serial Montgomery product sequencer (CIOS method). Computes R = A·B·2^(-64·NWORDS) mod N for odd N.
- Sits directly upstream of the combinational 64-bit multiply-add unit. Each cycle it drives one x·y+z+last_c operation into that unit and captures the 128-bit result {c,s}.
- Holds operand and accumulator arrays, performs the final conditional subtraction, and streams result words to the modexp controller.

---
 rtl/mon_pro_seq.sv | 176 +++++++++++++++++
 tb/tb_mon_pro_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mon_pro_seq.sv
// rtl/mon_pro_seq.sv - word-serial CIOS Montgomery product sequencer
// Issues one x*y+z+c per cycle to an external 64-bit multiply-add unit.
module mon_pro_seq #(
  parameter int NWORDS = 4,
  parameter int IDXW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_en,
  input  logic [1:0]      ld_sel,
  input  logic [IDXW-1:0] ld_idx,
  input  logic [63:0]     ld_data,
  input  logic [63:0]     n0_inv,
  input  logic            start,
  output logic            busy,
  output logic [63:0]     ma_x,
  output logic [63:0]     ma_y,
  output logic [63:0]     ma_z,
  output logic [63:0]     ma_last_c,
  input  logic [63:0]     ma_s,
  input  logic [63:0]     ma_c,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [63:0]     res_data,
  output logic            res_last
);
  localparam int DEPTH = 1 << IDXW;
  localparam logic [IDXW-1:0] LAST = IDXW'(NWORDS - 1);
  localparam logic [IDXW-1:0] ONE  = IDXW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_MTOP, S_MCALC, S_RED, S_RTOP, S_SUB, S_OUT
  } state_t;

  state_t state, state_nx;

  logic [63:0] a_mem [DEPTH];
  logic [63:0] b_mem [DEPTH];
  logic [63:0] n_mem [DEPTH];
  logic [63:0] t_mem [DEPTH];
  logic [63:0] d_mem [DEPTH];
  // t_top is T[NWORDS], t_ovf is T[NWORDS+1]
  logic [63:0] t_top, t_ovf, c_reg, m_reg;
  logic        borrow, sel_d;
  logic [IDXW-1:0] i_cnt, j_cnt;
  logic        j_last, i_last, j_first;
  logic [64:0] sub_res;

  assign j_last  = (j_cnt == LAST);
  assign i_last  = (i_cnt == LAST);
  assign j_first = (j_cnt == '0);
  assign sub_res = {1'b0, t_mem[j_cnt]} - {1'b0, n_mem[j_cnt]} - {64'd0, borrow};

  always_comb begin
    state_nx  = state;
    ma_x      = '0;
    ma_y      = '0;
    ma_z      = '0;
    ma_last_c = '0;
    case (state)
      S_IDLE:  if (start) state_nx = S_MUL;
      S_MUL: begin
        ma_x      = a_mem[j_cnt];
        ma_y      = b_mem[i_cnt];
        ma_z      = t_mem[j_cnt];
        ma_last_c = j_first ? '0 : c_reg;
        if (j_last) state_nx = S_MTOP;
      end
      S_MTOP: begin
        ma_z      = t_top;
        ma_last_c = c_reg;
        state_nx  = S_MCALC;
      end
      S_MCALC: begin
        ma_x     = t_mem[0];
        ma_y     = n0_inv;
        state_nx = S_RED;
      end
      S_RED: begin
        ma_x      = m_reg;
        ma_y      = n_mem[j_cnt];
        ma_z      = t_mem[j_cnt];
        ma_last_c = j_first ? '0 : c_reg;
        if (j_last) state_nx = S_RTOP;
      end
      S_RTOP: begin
        ma_z      = t_top;
        ma_last_c = c_reg;
        state_nx  = i_last ? S_SUB : S_MUL;
      end
      S_SUB:   if (j_last) state_nx = S_OUT;
      S_OUT:   if (res_ready && j_last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_OUT);
  assign res_data  = res_valid ? (sel_d ? d_mem[j_cnt] : t_mem[j_cnt]) : '0;
  assign res_last  = res_valid && j_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      for (int k = 0; k < DEPTH; k++) begin
        a_mem[k] <= '0;
        b_mem[k] <= '0;
        n_mem[k] <= '0;
        t_mem[k] <= '0;
        d_mem[k] <= '0;
      end
      t_top  <= '0;
      t_ovf  <= '0;
      c_reg  <= '0;
      m_reg  <= '0;
      borrow <= 1'b0;
      sel_d  <= 1'b0;
      i_cnt  <= '0;
      j_cnt  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (ld_en) begin
            case (ld_sel)
              2'd0:    a_mem[ld_idx] <= ld_data;
              2'd1:    b_mem[ld_idx] <= ld_data;
              2'd2:    n_mem[ld_idx] <= ld_data;
              default: ;
            endcase
          end
          if (start) begin
            for (int k = 0; k < DEPTH; k++) t_mem[k] <= '0;
            t_top <= '0;
            t_ovf <= '0;
            c_reg <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
          end
        end
        S_MUL: begin
          t_mem[j_cnt] <= ma_s;
          c_reg        <= ma_c;
          j_cnt        <= j_last ? '0 : j_cnt + ONE;
        end
        S_MTOP: begin
          t_top <= ma_s;
          t_ovf <= ma_c;
        end
        S_MCALC: m_reg <= ma_s;
        S_RED: begin
          // The low word at j=0 is zero by choice of m and is dropped (the shift).
          c_reg <= ma_c;
          if (!j_first) t_mem[j_cnt - ONE] <= ma_s;
          j_cnt <= j_last ? '0 : j_cnt + ONE;
        end
        S_RTOP: begin
          t_mem[LAST] <= ma_s;
          t_top       <= t_ovf + ma_c;
          borrow      <= 1'b0;
          i_cnt       <= i_last ? '0 : i_cnt + ONE;
        end
        S_SUB: begin
          d_mem[j_cnt] <= sub_res[63:0];
          borrow       <= sub_res[64];
          if (j_last) sel_d <= (t_top != '0) || !sub_res[64];
          j_cnt <= j_last ? '0 : j_cnt + ONE;
        end
        S_OUT: begin
          if (res_ready) j_cnt <= j_last ? '0 : j_cnt + ONE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mon_pro_seq.sv
// tb/tb_mon_pro_seq.sv - scoreboard bench for mon_pro_seq at NWORDS=4 and NWORDS=1
module tb_mon_pro_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ld_en4 = 1'b0, ld_en1 = 1'b0, start4 = 1'b0, start1 = 1'b0;
  logic        res_ready = 1'b1;
  logic [1:0]  ld_sel = '0, ld_idx = '0;
  logic [63:0] ld_data = '0, n0_inv = '0;

  logic        busy4, rv4, rl4, busy1, rv1, rl1;
  logic [63:0] rd4, x4, y4, z4, lc4, s4, c4;
  logic [63:0] rd1, x1, y1, z1, lc1, s1, c1;

  // Behavioural multiply-add units feeding each sequencer
  assign {c4, s4} = {64'd0, x4} * {64'd0, y4} + {64'd0, z4} + {64'd0, lc4};
  assign {c1, s1} = {64'd0, x1} * {64'd0, y1} + {64'd0, z1} + {64'd0, lc1};

  mon_pro_seq #(.NWORDS(4), .IDXW(2)) dut4 (
    .clk(clk), .rst(rst), .ld_en(ld_en4), .ld_sel(ld_sel), .ld_idx(ld_idx),
    .ld_data(ld_data), .n0_inv(n0_inv), .start(start4), .busy(busy4),
    .ma_x(x4), .ma_y(y4), .ma_z(z4), .ma_last_c(lc4), .ma_s(s4), .ma_c(c4),
    .res_valid(rv4), .res_ready(res_ready), .res_data(rd4), .res_last(rl4)
  );

  mon_pro_seq #(.NWORDS(1), .IDXW(1)) dut1 (
    .clk(clk), .rst(rst), .ld_en(ld_en1), .ld_sel(ld_sel), .ld_idx(ld_idx[0:0]),
    .ld_data(ld_data), .n0_inv(n0_inv), .start(start1), .busy(busy1),
    .ma_x(x1), .ma_y(y1), .ma_z(z1), .ma_last_c(lc1), .ma_s(s1), .ma_c(c1),
    .res_valid(rv1), .res_ready(res_ready), .res_data(rd1), .res_last(rl1)
  );

  logic        use1 = 1'b0;
  logic        cbusy, cvalid, clast;
  logic [63:0] cdata;
  assign cbusy  = use1 ? busy1 : busy4;
  assign cvalid = use1 ? rv1 : rv4;
  assign clast  = use1 ? rl1 : rl4;
  assign cdata  = use1 ? rd1 : rd4;

  int n_cmp = 0, n_bad = 0, n_seld = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [64:0] exp_q [$];
  logic [64:0] mon_e;

  always @(negedge clk) begin
    if (!rst && cvalid && res_ready) begin
      check("word_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("res_data", cdata, mon_e[63:0]);
        check("res_last", 64'(clast), 64'(mon_e[64]));
      end
    end
  end

  // Bit-serial Montgomery: returns T=(A*B+M*N)/2^(64*nw) before the final subtract
  function automatic logic [256:0] mont_t(input logic [255:0] a, b, n, input int nw);
    logic [513:0] x;
    x = {258'd0, a} * {258'd0, b};
    for (int i = 0; i < 64 * nw; i++) begin
      if (x[0]) x = x + {258'd0, n};
      x = x >> 1;
    end
    return x[256:0];
  endfunction

  function automatic logic [63:0] neg_inv(input logic [63:0] n0);
    logic [63:0] v;
    v = n0;
    for (int i = 0; i < 6; i++) v = v * (64'd2 - n0 * v);
    return -v;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom())};
    return v;
  endfunction

  task automatic load_ops(input bit w1, input logic [255:0] a, b, n);
    int nw = w1 ? 1 : 4;
    for (int sl = 0; sl < 4; sl++) begin
      for (int w = 0; w < nw; w++) begin
        ld_sel  = 2'(sl);
        ld_idx  = 2'(w);
        ld_data = (sl == 0) ? a[64*w +: 64] : (sl == 1) ? b[64*w +: 64] :
                  (sl == 2) ? n[64*w +: 64] : 64'hDEAD_BEEF_0BAD_F00D;
        if (w1) ld_en1 = 1'b1; else ld_en4 = 1'b1;
        @(posedge clk); #1;
      end
    end
    ld_en1 = 1'b0;
    ld_en4 = 1'b0;
  endtask

  task automatic run_op(input bit w1, input logic [255:0] a, b, n,
                        input bit fixed, input logic [255:0] fixed_r,
                        input bit stall, input bit inject, input int abort_at);
    int nw = w1 ? 1 : 4;
    int lat_exp = w1 ? 6 : 48;
    int k;
    logic [256:0] t;
    logic [255:0] r;
    use1   = w1;
    n0_inv = neg_inv(n[63:0]);
    load_ops(w1, a, b, n);
    t = mont_t(a, b, n, nw);
    if (t >= {1'b0, n}) begin
      r = 256'(t - {1'b0, n});
      n_seld++;
    end else begin
      r = t[255:0];
    end
    if (fixed) r = fixed_r;
    for (int w = 0; w < nw; w++) exp_q.push_back({w == nw - 1, r[64*w +: 64]});

    res_ready = !stall;
    if (w1) start1 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start4 = 1'b0;

    k = 0;
    while (!cvalid && k < 400) begin
      @(posedge clk); #1;
      k++;
      if (inject && k == 10) begin
        if (w1) start1 = 1'b1; else start4 = 1'b1;
        if (w1) ld_en1 = 1'b1; else ld_en4 = 1'b1;
        ld_sel  = 2'd2;
        ld_idx  = 2'd0;
        ld_data = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      if (inject && k == 11) begin
        start1 = 1'b0; start4 = 1'b0; ld_en1 = 1'b0; ld_en4 = 1'b0;
      end
      if (abort_at > 0 && k == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(cbusy), 64'd0);
        check("abort_valid", 64'(cvalid), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        res_ready = 1'b1;
        return;
      end
    end
    check("latency", 64'(k), 64'(lat_exp));
    if (!cvalid) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      res_ready = 1'b1;
      return;
    end

    for (int w = 0; w < nw; w++) begin
      if (stall && (w == 0 || w == 2)) begin
        res_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check("hold_valid", 64'(cvalid), 64'd1);
          check("hold_data", cdata, r[64*w +: 64]);
        end
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
    end
    check("busy_fall", 64'(cbusy), 64'd0);
    check("valid_fall", 64'(cvalid), 64'd0);
    check("q_drained", 64'(exp_q.size()), 64'd0);
  endtask

  logic [255:0] p, ra, rb, rn;

  initial begin
    p = {64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
         64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFED};
    #12;
    check("rst_busy4", 64'(busy4), 64'd0);
    check("rst_valid4", 64'(rv4), 64'd0);
    check("rst_last4", 64'(rl4), 64'd0);
    check("rst_data4", rd4, 64'd0);
    check("rst_ma_x", x4, 64'd0);
    check("rst_ma_y", y4, 64'd0);
    check("rst_ma_z", z4, 64'd0);
    check("rst_ma_c", lc4, 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    check("rst_valid1", 64'(rv1), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(1'b0, 256'd38, 256'd5, p, 1'b1, 256'd5, 1'b0, 1'b0, 0);
    run_op(1'b0, 256'd38, p - 256'd1, p, 1'b1, p - 256'd1, 1'b0, 1'b0, 0);
    ra = rnd256() % p;
    run_op(1'b0, 256'd0, ra, p, 1'b1, 256'd0, 1'b0, 1'b0, 0);
    run_op(1'b0, 256'd38, p - 256'd1, p, 1'b1, p - 256'd1, 1'b1, 1'b0, 0);
    run_op(1'b0, 256'd38, 256'd5, p, 1'b1, 256'd5, 1'b0, 1'b1, 0);
    run_op(1'b0, 256'd38, 256'd5, p, 1'b1, 256'd5, 1'b0, 1'b0, 20);
    run_op(1'b0, 256'd38, 256'd5, p, 1'b1, 256'd5, 1'b0, 1'b0, 0);

    for (int it = 0; it < 500; it++) begin
      rn = rnd256() | {2'b11, 254'd0} | 256'd1;
      ra = rnd256() % rn;
      rb = rnd256() % rn;
      run_op(1'b0, ra, rb, rn, 1'b0, 256'd0, 1'b0, 1'b0, 0);
    end
    for (int it = 0; it < 500; it++) begin
      rn = {192'd0, rnd256() [63:0] | {2'b11, 62'd0} | 64'd1};
      ra = {192'd0, rnd256() [63:0]} % rn;
      rb = {192'd0, rnd256() [63:0]} % rn;
      run_op(1'b1, ra, rb, rn, 1'b0, 256'd0, 1'b0, 1'b0, 0);
    end
    check("seld_cases", 64'(n_seld >= 50), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
